// File: rtl/spi_reg_frame.sv
// Register-file front end for a byte-oriented SPI slave: decodes a command byte,
// then streams writes into, or reads out of, a small byte-wide register file.
module spi_reg_frame #(
   parameter int          ADDR_W      = 4,
   parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        Trans_Start,
   input  logic                        Trans_End,
   input  logic                        Recive_Data_Valid,
   input  logic [7:0]                  Recive_Data,
   output logic                        Send_Data_Valid,
   output logic [7:0]                  Send_Data,
   output logic                        Wr_Strobe,
   output logic [ADDR_W-1:0]           Wr_Addr,
   output logic [7:0]                  Wr_Data,
   output logic [8*(2**ADDR_W)-1:0]    Reg_Out,
   output logic [7:0]                  Frame_Cnt,
   output logic                        Busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W-1:0]   r_ptr;
   logic [7:0]          r_regs [DEPTH];
   logic                r_readPend;
   logic                r_sendValid;
   logic [7:0]          r_sendData;
   logic                r_wrStrobe;
   logic [ADDR_W-1:0]   r_wrAddr;
   logic [7:0]          r_wrData;
   logic [7:0]          r_frameCnt;
   logic                r_busy;

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Trans_End outranks Trans_Start, which outranks any received byte
   always_comb begin
      w_nextState = r_state;
      if (Trans_End) begin
         w_nextState = IDLE;
      end else if (Trans_Start) begin
         w_nextState = CMD;
      end else if (r_state == CMD && Recive_Data_Valid) begin
         w_nextState = Recive_Data[7] ? READ : WRITE;
      end
   end

   // A read is fetched one cycle after it is requested, so the pointer used is
   // always the one already updated by the command byte or the previous read
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_ptr       <= '0;
         r_readPend  <= 1'b0;
         r_sendValid <= 1'b0;
         r_sendData  <= 8'h00;
         r_wrStrobe  <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= 8'h00;
         r_frameCnt  <= 8'h00;
         r_busy      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
      end else begin
         r_sendValid <= 1'b0;
         r_wrStrobe  <= 1'b0;
         r_busy      <= (w_nextState != IDLE);
         if (Trans_End && r_state != IDLE) r_frameCnt <= r_frameCnt + 8'd1;
         if (Trans_End) begin
            r_readPend <= 1'b0;
         end else if (Trans_Start) begin
            r_sendData  <= STATUS_BYTE;
            r_sendValid <= 1'b1;
            r_readPend  <= 1'b0;
         end else if (r_state == CMD) begin
            if (Recive_Data_Valid) begin
               r_ptr      <= Recive_Data[ADDR_W-1:0];
               r_readPend <= Recive_Data[7];
            end
         end else if (r_state == READ) begin
            if (r_readPend) begin
               r_sendData  <= r_regs[r_ptr];
               r_sendValid <= 1'b1;
               r_ptr       <= r_ptr + ADDR_W'(1);
            end
            r_readPend <= Recive_Data_Valid;
         end else if (r_state == WRITE && Recive_Data_Valid) begin
            r_regs[r_ptr] <= Recive_Data;
            r_ptr         <= r_ptr + ADDR_W'(1);
            r_wrStrobe    <= 1'b1;
            r_wrAddr      <= r_ptr;
            r_wrData      <= Recive_Data;
            r_sendData    <= Recive_Data;
            r_sendValid   <= 1'b1;
         end
      end
   end

   always_comb begin
      Reg_Out = '0;
      for (int i = 0; i < DEPTH; i++) Reg_Out[8*i +: 8] = r_regs[i];
   end

   assign Send_Data_Valid = r_sendValid;
   assign Send_Data       = r_sendData;
   assign Wr_Strobe       = r_wrStrobe;
   assign Wr_Addr         = r_wrAddr;
   assign Wr_Data         = r_wrData;
   assign Frame_Cnt       = r_frameCnt;
   assign Busy            = r_busy;

endmodule

// File: tb/tb_spi_reg_frame.sv
// Self-checking bench for spi_reg_frame: directed frames plus random frames
// compared against a byte-array model of the register file.
module tb_spi_reg_frame;

   localparam int         ADDR_W = 4;
   localparam int         DEPTH  = 2**ADDR_W;
   localparam logic [7:0] STATUS = 8'hA5;

   logic                  Clk = 1'b0;
   logic                  Rst = 1'b0;
   logic                  Trans_Start = 1'b0;
   logic                  Trans_End = 1'b0;
   logic                  Recive_Data_Valid = 1'b0;
   logic [7:0]            Recive_Data = 8'h00;
   logic                  Send_Data_Valid;
   logic [7:0]            Send_Data;
   logic                  Wr_Strobe;
   logic [ADDR_W-1:0]     Wr_Addr;
   logic [7:0]            Wr_Data;
   logic [8*DEPTH-1:0]    Reg_Out;
   logic [7:0]            Frame_Cnt;
   logic                  Busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] modelRegs [DEPTH];
   int         modelFrames;
   logic [7:0] expSend [$];
   int         expWrA [$];
   logic [7:0] expWrD [$];
   logic [7:0] gotSend [$];
   int         gotWrA [$];
   logic [7:0] gotWrD [$];
   logic [8*DEPTH-1:0] expFlat;

   spi_reg_frame #(.ADDR_W(ADDR_W), .STATUS_BYTE(STATUS)) dut (
      .Clk(Clk), .Rst(Rst), .Trans_Start(Trans_Start), .Trans_End(Trans_End),
      .Recive_Data_Valid(Recive_Data_Valid), .Recive_Data(Recive_Data),
      .Send_Data_Valid(Send_Data_Valid), .Send_Data(Send_Data),
      .Wr_Strobe(Wr_Strobe), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
      .Reg_Out(Reg_Out), .Frame_Cnt(Frame_Cnt), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (Send_Data_Valid) gotSend.push_back(Send_Data);
      if (Wr_Strobe) begin
         gotWrA.push_back(int'(Wr_Addr));
         gotWrD.push_back(Wr_Data);
      end
   end

   task automatic clearQueues();
      expSend.delete(); expWrA.delete(); expWrD.delete();
      gotSend.delete(); gotWrA.delete(); gotWrD.delete();
   endtask

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) modelRegs[i] = 8'h00;
      modelFrames = 0;
   endtask

   task automatic buildFlat();
      for (int i = 0; i < DEPTH; i++) expFlat[8*i +: 8] = modelRegs[i];
   endtask

   task automatic applyStart();
      @(negedge Clk); Trans_Start = 1'b1;
      @(negedge Clk); Trans_Start = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic applyByte(input logic [7:0] b);
      @(negedge Clk); Recive_Data_Valid = 1'b1; Recive_Data = b;
      @(negedge Clk); Recive_Data_Valid = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic applyEnd();
      @(negedge Clk); Trans_End = 1'b1;
      @(negedge Clk); Trans_End = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   // Drives a full frame and records what the SPI master should observe
   task automatic applyStimulus(input bit isRead, input int addr, input int n,
                                input logic [7:0] data [8]);
      applyStart();
      expSend.push_back(STATUS);
      applyByte({isRead, 3'b000, 4'(addr)});
      if (isRead) expSend.push_back(modelRegs[addr % DEPTH]);
      for (int i = 0; i < n; i++) begin
         applyByte(data[i]);
         if (isRead) begin
            expSend.push_back(modelRegs[(addr + i + 1) % DEPTH]);
         end else begin
            modelRegs[(addr + i) % DEPTH] = data[i];
            expWrA.push_back((addr + i) % DEPTH);
            expWrD.push_back(data[i]);
            expSend.push_back(data[i]);
         end
      end
      applyEnd();
      modelFrames = (modelFrames + 1) % 256;
   endtask

   task automatic test_reset();
      @(negedge Clk); Rst = 1'b1;
      repeat (2) @(negedge Clk); Rst = 1'b0;
      modelReset();
      checks++;
      if (Reg_Out !== '0 || Frame_Cnt !== 8'h00 || Busy !== 1'b0 || Send_Data !== 8'h00 ||
          Send_Data_Valid !== 1'b0 || Wr_Strobe !== 1'b0 || Wr_Addr !== '0 || Wr_Data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset: regs=%h cnt=%0d busy=%b sd=%h sdv=%b ws=%b wa=%0d wd=%h, required all zero",
                  Reg_Out, Frame_Cnt, Busy, Send_Data, Send_Data_Valid, Wr_Strobe, Wr_Addr, Wr_Data);
      end
   endtask

   task automatic test_write_burst();
      clearQueues();
      applyStart();
      checks++;
      if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_frame: got %b required 1", Busy); end
      applyByte(8'h03); applyByte(8'h11); applyByte(8'h22);
      applyEnd();
      checks++;
      if (Reg_Out[8*3 +: 8] !== 8'h11 || Reg_Out[8*4 +: 8] !== 8'h22) begin
         errors++;
         $display("[TB] FAIL write_burst_regs: reg3=%h reg4=%h required 11 22", Reg_Out[8*3 +: 8], Reg_Out[8*4 +: 8]);
      end
      checks++;
      if (gotWrA.size() !== 2 || gotWrA[0] !== 3 || gotWrA[1] !== 4 || gotWrD[0] !== 8'h11 || gotWrD[1] !== 8'h22) begin
         errors++;
         $display("[TB] FAIL write_burst_strobes: count=%0d required 2 at addr 3,4 data 11,22", gotWrA.size());
      end
      checks++;
      if (Frame_Cnt !== 8'd1 || Busy !== 1'b0) begin
         errors++; $display("[TB] FAIL write_burst_cnt: cnt=%0d busy=%b required 1 0", Frame_Cnt, Busy);
      end
      modelRegs[3] = 8'h11; modelRegs[4] = 8'h22; modelFrames = 1;
   endtask

   task automatic test_read_burst();
      clearQueues();
      applyStart(); applyByte(8'h83); applyByte(8'h00); applyEnd();
      checks++;
      if (gotSend.size() !== 3 || gotSend[0] !== 8'hA5 || gotSend[1] !== 8'h11 || gotSend[2] !== 8'h22) begin
         errors++;
         $display("[TB] FAIL read_burst_sequence: got %p required A5 11 22", gotSend);
      end
      checks++;
      if (Frame_Cnt !== 8'd2 || gotWrA.size() !== 0) begin
         errors++; $display("[TB] FAIL read_burst_cnt: cnt=%0d writes=%0d required 2 0", Frame_Cnt, gotWrA.size());
      end
      modelFrames = 2;
   endtask

   task automatic test_wrap();
      logic [7:0] d [8];
      clearQueues();
      d[0] = 8'hAA; d[1] = 8'hBB;
      applyStimulus(1'b0, 15, 2, d);
      checks++;
      if (Reg_Out[8*15 +: 8] !== 8'hAA || Reg_Out[7:0] !== 8'hBB) begin
         errors++;
         $display("[TB] FAIL wrap: reg15=%h reg0=%h required AA BB", Reg_Out[8*15 +: 8], Reg_Out[7:0]);
      end
      checks++;
      if (gotWrA.size() !== 2 || gotWrA[0] !== 15 || gotWrA[1] !== 0) begin
         errors++; $display("[TB] FAIL wrap_strobe_addr: got %p required 15 0", gotWrA);
      end
   endtask

   task automatic test_end_coincident();
      logic [7:0] before6;
      clearQueues();
      before6 = modelRegs[6];
      applyStart(); applyByte(8'h05); applyByte(8'h33);
      @(negedge Clk); Recive_Data_Valid = 1'b1; Recive_Data = 8'h44; Trans_End = 1'b1;
      @(negedge Clk); Recive_Data_Valid = 1'b0; Trans_End = 1'b0;
      repeat (3) @(negedge Clk);
      modelRegs[5] = 8'h33;
      modelFrames = (modelFrames + 1) % 256;
      checks++;
      if (Reg_Out[8*5 +: 8] !== 8'h33 || Reg_Out[8*6 +: 8] !== before6) begin
         errors++;
         $display("[TB] FAIL end_coincident_regs: reg5=%h reg6=%h required 33 %h", Reg_Out[8*5 +: 8], Reg_Out[8*6 +: 8], before6);
      end
      checks++;
      if (gotWrA.size() !== 1 || Busy !== 1'b0 || Frame_Cnt !== 8'(modelFrames)) begin
         errors++;
         $display("[TB] FAIL end_coincident_state: writes=%0d busy=%b cnt=%0d required 1 0 %0d", gotWrA.size(), Busy, Frame_Cnt, modelFrames);
      end
   endtask

   task automatic test_restart();
      clearQueues();
      applyStart(); applyByte(8'h01); applyByte(8'h77);
      applyStart(); applyByte(8'h81); applyByte(8'h00); applyEnd();
      modelRegs[1] = 8'h77;
      modelFrames = (modelFrames + 1) % 256;
      checks++;
      if (gotSend.size() !== 5 || gotSend[0] !== STATUS || gotSend[1] !== 8'h77 || gotSend[2] !== STATUS ||
          gotSend[3] !== 8'h77 || gotSend[4] !== modelRegs[2]) begin
         errors++;
         $display("[TB] FAIL restart_sequence: got %p required A5 77 A5 77 %h", gotSend, modelRegs[2]);
      end
      checks++;
      if (Frame_Cnt !== 8'(modelFrames)) begin
         errors++; $display("[TB] FAIL restart_cnt: got %0d required %0d", Frame_Cnt, modelFrames);
      end
   endtask

   task automatic test_random();
      logic [7:0] d [8];
      bit         isRead;
      int         addr, n;
      for (int f = 0; f < 10; f++) begin
         clearQueues();
         isRead = 1'($urandom_range(0, 1));
         addr   = $urandom_range(0, DEPTH-1);
         n      = $urandom_range(0, 5);
         for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
         applyStimulus(isRead, addr, n, d);
         buildFlat();
         checks++;
         if (gotSend.size() !== expSend.size()) begin
            errors++; $display("[TB] FAIL random_send_count frame %0d: got %0d required %0d", f, gotSend.size(), expSend.size());
         end else begin
            for (int i = 0; i < expSend.size(); i++) begin
               checks++;
               if (gotSend[i] !== expSend[i]) begin
                  errors++; $display("[TB] FAIL random_send frame %0d byte %0d: got %h required %h", f, i, gotSend[i], expSend[i]);
               end
            end
         end
         checks++;
         if (gotWrA != expWrA || gotWrD != expWrD) begin
            errors++; $display("[TB] FAIL random_writes frame %0d: got %p/%p required %p/%p", f, gotWrA, gotWrD, expWrA, expWrD);
         end
         checks++;
         if (Reg_Out !== expFlat || Frame_Cnt !== 8'(modelFrames)) begin
            errors++; $display("[TB] FAIL random_state frame %0d: regs=%h cnt=%0d required %h %0d", f, Reg_Out, Frame_Cnt, expFlat, modelFrames);
         end
      end
   endtask

   task automatic test_idle_rdv();
      clearQueues();
      applyByte(8'h12);
      buildFlat();
      checks++;
      if (gotSend.size() !== 0 || gotWrA.size() !== 0 || Busy !== 1'b0 ||
          Reg_Out !== expFlat || Frame_Cnt !== 8'(modelFrames)) begin
         errors++;
         $display("[TB] FAIL idle_rdv: sends=%0d writes=%0d busy=%b cnt=%0d required 0 0 0 %0d", gotSend.size(), gotWrA.size(), Busy, Frame_Cnt, modelFrames);
      end
   endtask

   task automatic test_reset_midframe();
      clearQueues();
      applyStart(); applyByte(8'h02);
      @(negedge Clk); Rst = 1'b1;
      @(negedge Clk); Rst = 1'b0;
      applyByte(8'h55);
      applyEnd();
      modelReset();
      checks++;
      if (Reg_Out !== '0 || gotWrA.size() !== 0 || Frame_Cnt !== 8'h00 || Busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_midframe: regs=%h writes=%0d cnt=%0d busy=%b required 0 0 0 0", Reg_Out, gotWrA.size(), Frame_Cnt, Busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_end_coincident();
      test_restart();
      test_random();
      test_idle_rdv();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_frame.md
SPI_REG_FRAME -- requirements
Module: spi_reg_frame

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set register-file address width; depth is 2**ADDR_W bytes.
REQ-002 Parameter STATUS_BYTE, default 8'hA5, SHALL be the byte loaded for MISO at frame start.
REQ-003 Clk  input  1  single system clock; all logic SHALL be on posedge Clk.
REQ-004 Rst  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 Trans_Start  input  1  one-cycle pulse from the SPI slave: CS asserted.
REQ-006 Trans_End  input  1  one-cycle pulse from the SPI slave: CS deasserted.
REQ-007 Recive_Data_Valid  input  1  one-cycle pulse: Recive_Data holds a new byte.
REQ-008 Recive_Data  input  8  byte received from the SPI master.
REQ-009 Send_Data_Valid  output  1  one-cycle pulse: Send_Data is to be latched by the SPI slave.
REQ-010 Send_Data  output  8  next byte for the SPI slave to shift out on MISO.
REQ-011 Wr_Strobe  output  1  one-cycle pulse per register write.
REQ-012 Wr_Addr  output  ADDR_W  address of the current write.
REQ-013 Wr_Data  output  8  data of the current write.
REQ-014 Reg_Out  output  8*2**ADDR_W  flat register-file image; reg[i] occupies bits [8i+7:8i].
REQ-015 Frame_Cnt  output  8  count of completed frames; wraps 255->0.
REQ-016 Busy  output  1  high while the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, CMD, WRITE and READ.
REQ-018 IDLE->CMD on Trans_Start; in the same cycle Send_Data<=STATUS_BYTE and Send_Data_Valid pulses.
REQ-019 CMD byte format: bit7 1=read/0=write; bits[ADDR_W-1:0] start address; other bits ignored.
REQ-020 In CMD, on Recive_Data_Valid: address pointer <= cmd[ADDR_W-1:0]; next state READ if bit7=1, else WRITE.
REQ-021 CMD->READ SHALL, on the next cycle, drive Send_Data<=reg[ptr], pulse Send_Data_Valid, and set ptr<=ptr+1.
REQ-022 In READ, each Recive_Data_Valid SHALL, on the next cycle, drive Send_Data<=reg[ptr], pulse Send_Data_Valid, and set ptr<=ptr+1; received data is discarded.
REQ-023 Send_Data_Valid SHALL pulse no later than 2 Clk cycles after Recive_Data_Valid, so the SPI slave latches it before the next byte starts.
REQ-024 In WRITE, each Recive_Data_Valid SHALL write reg[ptr]<=Recive_Data and set ptr<=ptr+1 on the same edge.
REQ-025 In WRITE, each Recive_Data_Valid SHALL pulse Wr_Strobe one cycle later, with Wr_Addr=old ptr and Wr_Data=byte.
REQ-026 In WRITE, Send_Data SHALL be the echo of the last byte written, with a Send_Data_Valid pulse.
REQ-027 ptr SHALL wrap modulo 2**ADDR_W; for ADDR_W=4, 15->0.
REQ-028 Any state->IDLE on Trans_End; Frame_Cnt SHALL increment by 1 if the state was not IDLE.
REQ-029 Trans_End SHALL have priority over a coincident Recive_Data_Valid; that byte is dropped and no write occurs.
REQ-030 Trans_Start while not IDLE SHALL restart at CMD without incrementing Frame_Cnt.
REQ-031 Recive_Data_Valid in IDLE SHALL be ignored.
REQ-032 A frame of only the CMD byte SHALL cause no register change; it still counts in Frame_Cnt.
REQ-033 Reg_Out SHALL reflect a write one cycle after the write edge.
REQ-034 Busy SHALL equal (state!=IDLE), registered.

Reset
REQ-035 On Rst=1 at posedge Clk: state=IDLE, ptr=0, all registers=8'h00, Send_Data=8'h00, Send_Data_Valid=0, Wr_Strobe=0, Wr_Addr=0, Wr_Data=0, Frame_Cnt=0, Busy=0.
REQ-036 Rst mid-frame SHALL abort the frame without incrementing Frame_Cnt; a later Trans_End in IDLE SHALL have no effect.
REQ-037 Rst SHALL take priority over all other inputs.

Verification
REQ-038 Write burst: Start, 0x03, 0x11, 0x22, End -> reg3=0x11, reg4=0x22, two Wr_Strobe pulses (addr 3, then 4), Frame_Cnt=1.
REQ-039 Read burst after REQ-038: Start (Send_Data=0xA5), 0x83, dummy, End -> Send_Data sequence 0xA5, 0x11, 0x22; Frame_Cnt=2.
REQ-040 Wrap: write frame 0x0F, 0xAA, 0xBB -> reg15=0xAA, reg0=0xBB.
REQ-041 Trans_End coincident with the third byte of a write frame -> byte not written, no Wr_Strobe, state IDLE.
REQ-042 Rst asserted after the CMD byte of a write frame, then 0x55 valid -> no write, all registers 0, Frame_Cnt=0.
REQ-043 Recive_Data_Valid with 0x12 while IDLE -> no state change, no Send_Data_Valid, no write.
